rr_merge_arbiter: RTL
=====================

RR_MERGE_ARBITER -- requirements
Module: rr_merge_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning number of source FIFOs (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of one packet word.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum number of consecutive words taken from one port per grant (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port din, input, NUM_PORTS*DATA_WIDTH bits: source data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port empty, input, NUM_PORTS bits: source FIFO empty flags.
REQ-008 The block SHALL have port port_en, input, NUM_PORTS bits: a 0 on bit i excludes port i from arbitration.
REQ-009 The block SHALL have port out_full, input, 1 bit: destination FIFO full flag, driven as almost-full with at least 1 word of reserve.
REQ-010 The block SHALL have port read_en, output, NUM_PORTS bits: registered, one-hot-or-zero pop strobes.
REQ-011 The block SHALL have port dout, output, DATA_WIDTH bits: registered output word.
REQ-012 The block SHALL have port wen, output, 1 bit: registered destination write strobe.
REQ-013 The block SHALL have port grant_port, output, clog2(NUM_PORTS) bits: index of the current or last granted port.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 Eligible(i) SHALL be defined as !empty[i] && port_en[i], sampled at the deciding edge.
REQ-016 The block SHALL implement the states IDLE, READ, WRITE and STALL.
REQ-017 In IDLE with any port eligible, the block SHALL select the first eligible index at or after rr_ptr (circular), set grant_port to it, assert read_en[g] and enter READ; with no port eligible it SHALL remain in IDLE.
REQ-018 read_en[g] SHALL be high for exactly one cycle (the READ cycle); READ SHALL always go to WRITE, with read_en cleared.
REQ-019 Sources SHALL present popped data on din one cycle after read_en is sampled, i.e. during the WRITE cycle.
REQ-020 In WRITE with out_full=0, the block SHALL set dout to din[g] and wen to 1 for one cycle; with out_full=1 it SHALL capture din[g] into a hold register and enter STALL.
REQ-021 In STALL, the block SHALL remain while out_full=1; when out_full=0 it SHALL set dout to hold and wen to 1.
REQ-022 After a word is written, the block SHALL increment burst_cnt; if burst_cnt < BURST_MAX and port g is still eligible, it SHALL go to READ with read_en[g]=1; otherwise it SHALL set rr_ptr to (g+1) mod NUM_PORTS, clear burst_cnt and go to IDLE.
REQ-023 wen SHALL be 0 in every cycle not named in REQ-020/021; each popped word SHALL be written exactly once, in order.
REQ-024 Deasserting port_en mid-burst SHALL end the burst after the in-flight word; that word SHALL still be delivered.
REQ-025 Throughput SHALL be 3 cycles per word for a first word and 2 cycles per word within a burst, given out_full=0.
REQ-026 With all ports continuously eligible, every port SHALL receive a grant within NUM_PORTS grants.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set state to IDLE, read_en to 0, dout to 0, wen to 0, grant_port to 0, busy to 0, rr_ptr to 0, burst_cnt to 0 and hold to 0.
REQ-028 Reset asserted mid-operation SHALL discard any word already popped from a source and not yet written.

Structure
REQ-029 The state encoding and the BURST counter width rule SHALL be defined in the shared package merge_pkg.
REQ-030 Round-robin selection SHALL be placed in a combinational sub-module rr_pick (inputs: eligible mask, rr_ptr; outputs: any, index).

Verification (NUM_PORTS=4, DATA_WIDTH=32, BURST_MAX=2)
REQ-031 The bench SHALL check a single word: port 2 holds 0xA5, others empty -> read_en=4'b0100 one cycle, wen with dout=0xA5 two cycles later, rr_ptr=3.
REQ-032 The bench SHALL check fairness: all ports hold 3 words -> grant order 0,0,1,1,2,2,3,3,0,..., never more than 2 consecutive words per port.
REQ-033 The bench SHALL check backpressure: out_full=1 during WRITE for 5 cycles -> no wen, no further read_en, then exactly one wen carrying the held word.
REQ-034 The bench SHALL check the enable mask: port_en=4'b1011 with all ports non-empty -> port 2 never granted; clearing port_en[0] mid-burst -> current word delivered, next grant goes to port 1.
REQ-035 The bench SHALL check reset: rst asserted in WRITE -> next cycle all outputs 0 and busy=0; after release the first grant goes to port 0.

Source files
------------

// File: rtl/merge_pkg.sv
// merge_pkg: shared FSM encoding and burst counter sizing for the merge arbiter
package merge_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, STALL} state_e;
  function automatic int burst_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular first-eligible search starting at the round-robin pointer
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic         any_o,
  output logic [W-1:0] index_o
);
  // scan from farthest to nearest so the nearest eligible index wins
  always_comb begin
    any_o = |eligible_i;
    index_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_ptr_i) + k) % N;
      if (eligible_i[j]) index_o = W'(j);
    end
  end
endmodule

// File: rtl/rr_merge_arbiter.sv
// rr_merge_arbiter: round-robin burst merge of several source FIFOs into one destination
module rr_merge_arbiter
  import merge_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            empty,
  input  logic [NUM_PORTS-1:0]            port_en,
  input  logic                            out_full,
  output logic [NUM_PORTS-1:0]            read_en,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            wen,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_port,
  output logic                            busy
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = burst_w(BURST_MAX);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         g_q, g_d, ptr_q, ptr_d, pick;
  logic [BW-1:0]         burst_q, burst_d, burst_inc;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, dout_q, dout_d, din_g;
  logic [NUM_PORTS-1:0]  elig, read_en_q, read_en_d;
  logic                  wen_q, wen_d, any, written;

  assign elig = ~empty & port_en;
  assign din_g = din[g_q*DATA_WIDTH +: DATA_WIDTH];
  assign burst_inc = burst_q + BW'(1);
  assign read_en = read_en_q;
  assign dout = dout_q;
  assign wen = wen_q;
  assign grant_port = g_q;
  assign busy = state_q != IDLE;

  rr_pick #(.N(NUM_PORTS), .W(PW)) u_pick (
    .eligible_i(elig),
    .rr_ptr_i  (ptr_q),
    .any_o     (any),
    .index_o   (pick)
  );

  // next state: grant, pop, write or hold, then continue the burst or rotate the pointer
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    ptr_d = ptr_q;
    burst_d = burst_q;
    hold_d = hold_q;
    dout_d = dout_q;
    wen_d = 1'b0;
    read_en_d = '0;
    written = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        g_d = pick;
        read_en_d[pick] = 1'b1;
        state_d = READ;
      end
      READ: state_d = WRITE;
      WRITE: if (!out_full) begin
        dout_d = din_g;
        wen_d = 1'b1;
        written = 1'b1;
      end else begin
        hold_d = din_g;
        state_d = STALL;
      end
      STALL: if (!out_full) begin
        dout_d = hold_q;
        wen_d = 1'b1;
        written = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (written) begin
      if (burst_inc < BMAX && elig[g_q]) begin
        burst_d = burst_inc;
        read_en_d[g_q] = 1'b1;
        state_d = READ;
      end else begin
        burst_d = '0;
        ptr_d = g_q == LAST ? '0 : g_q + PW'(1);
        state_d = IDLE;
      end
    end
  end

  // state and registered outputs; reset drops any popped but unwritten word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      ptr_q <= '0;
      burst_q <= '0;
      hold_q <= '0;
      dout_q <= '0;
      wen_q <= 1'b0;
      read_en_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      burst_q <= burst_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
      wen_q <= wen_d;
      read_en_q <= read_en_d;
    end
  end
endmodule
